// File: rtl/icache_fill_fsm.sv
// Cache miss fill controller: streams an 8-word block from pipelined main memory
// into the cache data array, then writes the tag on the final returned word.
module icache_fill_fsm #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              write_data_array,
  output logic [2:0]        fill_word_sel,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);

  localparam int unsigned OFF_W = 4;
  localparam logic [3:0]  WORDS = 4'(BLOCK_WORDS);
  localparam logic [3:0]  LAST  = 4'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e                    state_q;
  logic [ADDR_W-OFF_W-1:0]   base_q;
  logic [3:0]                issue_q;
  logic [3:0]                recv_q;
  logic                      issue_go;
  logic                      beat;
  logic                      unused_offset;

  assign unused_offset = ^miss_address[OFF_W-1:0];

  // Response-side outputs must react to memory_data_valid in the same cycle,
  // so they are decoded from the registered state rather than registered.
  always_comb begin
    issue_go         = (state_q == FILL) && (issue_q < WORDS);
    beat             = (state_q == FILL) && memory_data_valid;
    memory_read_en   = issue_go;
    memory_address   = issue_go ? {base_q, issue_q[2:0], 1'b0} : '0;
    write_data_array = beat;
    fill_word_sel    = beat ? recv_q[2:0] : '0;
    write_tag_array  = beat && (recv_q == LAST);
    fill_data        = memory_data;
    fsm_busy         = ~rst & ((state_q == FILL) | miss_detected);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base_q  <= miss_address[ADDR_W-1:OFF_W];
            issue_q <= '0;
            recv_q  <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (issue_go) issue_q <= issue_q + 4'd1;
          if (beat) begin
            recv_q <= recv_q + 4'd1;
            if (recv_q == LAST) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Self-checking bench for icache_fill_fsm: each fill is described by the cycle
// numbers of its eight response valids; expectations follow from that schedule.
module tb_icache_fill_fsm;

  typedef int unsigned vc_t [8];

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        write_data_array;
  logic [2:0]  fill_word_sel;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  icache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .memory_read_en(memory_read_en),
    .memory_address(memory_address), .memory_data(memory_data),
    .memory_data_valid(memory_data_valid), .write_data_array(write_data_array),
    .fill_word_sel(fill_word_sel), .fill_data(fill_data),
    .write_tag_array(write_tag_array)
  );

  function automatic vc_t fixed_lat(input int unsigned first);
    vc_t v;
    for (int unsigned j = 0; j < 8; j++) v[j] = first + j;
    return v;
  endfunction

  function automatic vc_t random_sched();
    vc_t v;
    int unsigned lat, lo, prev;
    lat  = $urandom_range(0, 5);
    prev = 0;
    for (int unsigned j = 0; j < 8; j++) begin
      lo   = (j + 1 + lat > prev + 1) ? j + 1 + lat : prev + 1;
      v[j] = lo + $urandom_range(0, 2);
      prev = v[j];
    end
    return v;
  endfunction

  // Drives one fill from detection (cycle 0) through the last response.
  // A non-negative abort asserts rst between edges in that cycle and stops.
  task automatic run_fill(input logic [15:0] a, input vc_t vc, input bit hold, input int abort);
    logic [15:0] words [8];
    logic [15:0] base, exp_addr;
    bit          v, exp_rd;
    int unsigned k;
    base = {a[15:4], 4'h0};
    foreach (words[i]) words[i] = 16'($urandom);
    for (int unsigned t = 0; t <= vc[7]; t++) begin
      v = 1'b0; k = 0;
      for (int unsigned j = 0; j < 8; j++) if (vc[j] == t) begin v = 1'b1; k = j; end
      miss_detected     = (t == 0) ? 1'b1 : hold;
      miss_address      = (t == 0) ? a : 16'hBEEE;
      memory_data_valid = v;
      memory_data       = v ? words[k] : 16'($urandom);
      if (abort >= 0 && int'(t) == abort) begin
        #2;
        rst = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b0;
        #1;
        n_tests++;
        if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0 ||
            memory_address !== 16'h0 || fill_word_sel !== 3'd0) begin
          n_fail++;
          $display("FAIL async_reset_outputs t=%0d got busy=%b rd=%b addr=%h wr=%b sel=%0d tag=%b exp all 0",
                   t, fsm_busy, memory_read_en, memory_address, write_data_array, fill_word_sel, write_tag_array);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      exp_rd   = (t >= 1 && t <= 8);
      exp_addr = exp_rd ? base + 16'(2 * (t - 1)) : 16'h0;
      #4;
      n_tests++;
      if (fsm_busy !== 1'b1) begin
        n_fail++; $display("FAIL busy a=%h t=%0d got %b exp 1", a, t, fsm_busy);
      end
      n_tests++;
      if (memory_read_en !== exp_rd) begin
        n_fail++; $display("FAIL read_en a=%h t=%0d got %b exp %b", a, t, memory_read_en, exp_rd);
      end
      n_tests++;
      if (memory_address !== exp_addr) begin
        n_fail++; $display("FAIL mem_addr a=%h t=%0d got %h exp %h", a, t, memory_address, exp_addr);
      end
      n_tests++;
      if (write_data_array !== v) begin
        n_fail++; $display("FAIL data_write a=%h t=%0d got %b exp %b", a, t, write_data_array, v);
      end
      if (v) begin
        n_tests++;
        if (fill_word_sel !== 3'(k)) begin
          n_fail++; $display("FAIL word_sel a=%h t=%0d got %0d exp %0d", a, t, fill_word_sel, k);
        end
      end
      n_tests++;
      if (write_tag_array !== (v && k == 7)) begin
        n_fail++; $display("FAIL tag_write a=%h t=%0d got %b exp %b", a, t, write_tag_array, v && k == 7);
      end
      n_tests++;
      if (fill_data !== memory_data) begin
        n_fail++; $display("FAIL fill_data a=%h t=%0d got %h exp %h", a, t, fill_data, memory_data);
      end
      @(posedge clk); #1;
    end
  endtask

  // Idle cycles with stray valids: nothing may be requested or written.
  task automatic test_idle(input int unsigned n);
    for (int unsigned t = 0; t < n; t++) begin
      miss_detected     = 1'b0;
      miss_address      = 16'($urandom);
      memory_data_valid = 1'($urandom_range(0, 1));
      memory_data       = 16'($urandom);
      #4;
      n_tests++;
      if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0 ||
          memory_address !== 16'h0) begin
        n_fail++;
        $display("FAIL idle_quiet t=%0d got busy=%b rd=%b addr=%h wr=%b tag=%b exp all 0",
                 t, fsm_busy, memory_read_en, memory_address, write_data_array, write_tag_array);
      end
      n_tests++;
      if (fill_data !== memory_data) begin
        n_fail++; $display("FAIL idle_fill_data t=%0d got %h exp %h", t, fill_data, memory_data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h1236;
    memory_data_valid = 1'b1; memory_data = 16'hA5A5;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({fsm_busy, memory_read_en, write_data_array, write_tag_array} !== 4'b0 ||
        memory_address !== 16'h0 || fill_word_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b rd=%b addr=%h wr=%b sel=%0d tag=%b exp all 0",
               fsm_busy, memory_read_en, memory_address, write_data_array, fill_word_sel, write_tag_array);
    end
    n_tests++;
    if (fill_data !== 16'hA5A5) begin
      n_fail++; $display("FAIL reset_fill_data got %h exp a5a5", fill_data);
    end
    miss_detected = 1'b0; memory_data_valid = 1'b0;
    rst = 1'b0;
    test_idle(6);
  endtask

  task automatic test_basic();
    run_fill(16'h1236, fixed_lat(5), 1'b0, -1);
    test_idle(1);
  endtask

  task automatic test_gaps();
    vc_t g;
    g = '{5, 7, 8, 11, 12, 13, 16, 17};
    run_fill(16'h1236, g, 1'b0, -1);
    test_idle(1);
  endtask

  task automatic test_hold_miss();
    run_fill(16'h1236, fixed_lat(5), 1'b1, -1);
    test_idle(1);
  endtask

  task automatic test_back_to_back();
    run_fill(16'h0000, fixed_lat(5), 1'b0, -1);
    run_fill(16'h0010, fixed_lat(5), 1'b0, -1);
    test_idle(1);
  endtask

  task automatic test_zero_latency();
    run_fill(16'hFFFE, fixed_lat(1), 1'b0, -1);
    run_fill(16'h8001, fixed_lat(2), 1'b0, -1);
    test_idle(1);
  endtask

  task automatic test_reset_mid_fill();
    run_fill(16'h1236, fixed_lat(5), 1'b0, 7);
    test_idle(4);
    run_fill(16'h4A5C, fixed_lat(5), 1'b0, -1);
    test_idle(1);
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 25; i++) begin
      run_fill(16'($urandom), random_sched(), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 2) != 0) test_idle($urandom_range(1, 3));
    end
    test_idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_hold_miss();
    test_back_to_back();
    test_zero_latency();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/icache_fill_fsm.md
# icache_fill_fsm

Miss-handling controller for the instruction cache that sits directly upstream of the pipelined cpu's fetch stage and replaces its single-cycle instruction memory path. On a cache miss it stalls fetch, streams the 8-word block containing the missed address from the multi-cycle main memory, writes each returned word into the cache data array, and writes the tag on the final word. The same block is instantiated a second time for the data cache.

## Interface
- BLOCK_WORDS, 8, 16-bit words per cache block; the block supports the value 8 only (3-bit word offset).
- ADDR_W, 16, byte-address width.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  in  16  byte address of the missing access; valid with miss_detected.
- fsm_busy  out  1  fill in progress; the cpu holds PC and IF/ID while high.
- memory_read_en  out  1  read request to main memory this cycle.
- memory_address  out  16  word-aligned request address; 0 when memory_read_en is low.
- memory_data  in  16  read data from main memory.
- memory_data_valid  in  1  memory_data is valid this cycle.
- write_data_array  out  1  write fill_data into the data array at fill_word_sel.
- fill_word_sel  out  3  word offset within the block being written.
- fill_data  out  16  combinational pass-through of memory_data.
- write_tag_array  out  1  write the tag for the block and set its valid bit.

## Operation
- States: IDLE, FILL.
- IDLE:
  - On miss_detected, latch block_base = miss_address[15:4] and clear issue_cnt and recv_cnt (both 4-bit, range 0..8).
  - Go to FILL at the next edge.
  - memory_data_valid is ignored in IDLE.
- FILL, request side:
  - memory_read_en = (issue_cnt < 8).
  - memory_address = {block_base, issue_cnt[2:0], 1'b0}.
  - issue_cnt increments on each issued request and saturates at 8.
  - Requests are pipelined: one per cycle, with no wait on responses.
- FILL, response side: on each memory_data_valid:
  - write_data_array = 1.
  - fill_word_sel = recv_cnt[2:0].
  - recv_cnt increments.
  - Responses return in issue order; word order is purely count-based, so no latency is assumed.
- FILL completion:
  - When memory_data_valid arrives with recv_cnt == 7, write_tag_array = 1 in the same cycle as the last data write.
  - The state returns to IDLE at the next edge.
- fsm_busy = (state == FILL) | (state == IDLE & miss_detected). This is a Mealy output, so the stall takes effect in the same cycle the miss is detected.
- miss_detected is ignored during FILL; the cache re-looks up after fsm_busy drops.
- Reset is asynchronous and sets:
  - state = IDLE
  - block_base, issue_cnt and recv_cnt = 0
  - all outputs = 0, except fill_data, which follows memory_data.
- Main memory shares rst, so a mid-fill reset leaves no responses in flight.
- Reset mid-FILL abandons the fill: no tag write occurs and the block stays invalid.

## Timing
- Cycle numbering: the miss is detected in cycle 0 (IDLE); FILL is entered at cycle 1.
- Requests are issued in cycles 1..8 for words 0..7.
- With the 4-cycle memory, valids arrive in cycles 5..12:
  - data writes occur in cycles 5..12;
  - write_tag_array fires in cycle 12;
  - fsm_busy is high in cycles 0..12 and low in cycle 13.
- Total miss penalty with the 4-cycle memory is 13 cycles.
- A new miss_detected in cycle 13 starts a new fill immediately, with no dead cycle.
- If memory_data_valid coincides with the last request issue (latency ≤ 1), both actions occur in the same cycle.
- Gaps in memory_data_valid stretch FILL without corrupting word order.

## Test plan
- Reset, then idle:
  - every output is 0 and fsm_busy stays 0;
  - valid pulses on memory_data_valid produce no writes.
- Miss at 0x1236 with the 4-cycle memory:
  - memory_address steps 0x1230, 0x1232, …, 0x123E in cycles 1..8;
  - write_data_array fires in cycles 5..12 with fill_word_sel 0..7;
  - write_tag_array fires in cycle 12 only;
  - fsm_busy covers cycles 0..12.
- Irregular valid gaps (e.g. valids at cycles 5, 7, 8, 11, 12, 13, 16, 17):
  - exactly 8 writes occur with sel 0..7 in order;
  - write_tag_array fires at cycle 17;
  - fsm_busy falls at cycle 18.
- miss_detected held high during FILL with miss_address = 0xBEEE:
  - the fill continues on block 0x123x unaffected.
- Back-to-back misses (0x0000, then 0x0010 asserted in the cycle after the tag write):
  - the second fill's first request (0x0010) is issued one cycle after detection, with no extra idle cycle.
- rst asserted in cycle 7 of a fill, asynchronously between edges:
  - outputs go to 0 immediately and no tag write occurs;
  - a subsequent miss fills a complete block correctly.
